// File: rtl/loadable_downcount.sv
// Loadable down-counting timer with registered terminal-count pulse,
// one-shot / auto-reload modes and an IDLE/RUN/DONE state machine.
module loadable_downcount #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             reload_mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (load) begin
      q_d     = data_in;
      rld_d   = data_in;
      state_d = (data_in != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      // q==0 in RUN cannot occur; folding it into expiry keeps the count from wrapping
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (reload_mode) begin
          q_d = rld_q;
        end else begin
          q_d     = '0;
          state_d = DONE;
        end
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/loadable_downcount.md
# loadable_downcount

Loadable down-counting timer that pairs with the team's 4-bit loadable up-counter. It counts a loaded value down to zero and flags expiry with a registered terminal-count pulse. It supports one-shot and auto-reload modes, so it can pace or time out the up-counter side of a datapath. A three-state FSM (IDLE/RUN/DONE) tracks whether a count is in progress.

## Interface
- WIDTH, 4, counter and data width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- load  input  1  synchronous load strobe; highest priority after reset
- data_in  input  WIDTH  start/reload value, sampled only when load=1
- en  input  1  count enable; the counter decrements only when en=1
- reload_mode  input  1  0 = one-shot, 1 = auto-reload; sampled at the expiry edge
- q  output  WIDTH  current count
- tc  output  1  terminal-count pulse, one cycle per expiry
- busy  output  1  1 while in RUN
- done  output  1  1 while in DONE (one-shot expired)

## Operation
- Reset (rst=0, asynchronous): q=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. Outputs update immediately on reset assertion, not at the next clock edge.
- Priority at each rising edge: load, then en, then hold.
- load=1, data_in≠0:
  - q←data_in, reload register←data_in, state←RUN.
  - This applies in any state, including mid-count (restart) and in DONE.
- load=1, data_in=0: q←0, reload register←0, state←IDLE, no tc.
- RUN, en=1, q>1: q←q−1.
- RUN, en=1, q=1 (expiry edge): tc←1 for the next cycle.
  - If reload_mode=0: q←0, state←DONE.
  - If reload_mode=1: q←reload register, state stays RUN.
- RUN, en=0: q, state and reload register hold; tc←0.
- IDLE and DONE: q holds, en is ignored, tc=0.
- busy=(state==RUN) and done=(state==DONE), both registered and consistent with state.
- Arithmetic is unsigned WIDTH bits. q never underflows: RUN with q=0 is unreachable.
- The reload register changes only on load.

## Timing
- All outputs are registered and change only on the rising clk edge, except on asynchronous reset.
- Load to count:
  - q equals data_in in the cycle after the load edge.
  - The first decrement happens at the next edge that has en=1.
- One-shot: after loading N with en held at 1, q shows N, N−1, …, 1, then 0.
  - tc=1 and done=1 appear together in the cycle q first shows 0.
  - Total of N edges from the first enabled edge to expiry.
- Auto-reload: tc pulses once every N enabled cycles.
  - q sequence is N…1, N…1, and q never shows 0.
  - With N=1, tc stays high continuously while en=1.
- en gaps stretch the period cycle-for-cycle. tc never asserts on a cycle following an en=0 edge.
- load on the expiry edge: load wins. No tc is produced, and q←data_in.
- reload_mode change mid-count affects only the next expiry edge.
- rst asserted mid-count: immediate return to the reset values. After release, the block stays in IDLE until a load.
- rst deassertion: treated as synchronous to clk by the surrounding design; no internal synchronizer.

## Test plan
- Reset check:
  - Stimulus: load 4'b1010, count a few cycles, then assert rst=0 mid-clock.
  - Required: q=0, tc=0, busy=0, done=0 immediately, before the next edge; block stays IDLE after release.
- One-shot:
  - Stimulus: load 4'b0011, reload_mode=0, en=1.
  - Required: q=3,2,1,0; tc=1 exactly one cycle as q→0; done=1 and held; further en pulses leave q=0.
- Auto-reload:
  - Stimulus: load 4'b0100, reload_mode=1, en=1 for 12 cycles.
  - Required: q=4,3,2,1,4,3,2,1,4,…; tc pulses 3 times, spaced 4 cycles apart; busy stays 1.
- Enable gating:
  - Stimulus: load 4'b0101, toggle en 1,0,0,1,…
  - Required: q holds during en=0 and expiry is delayed by exactly the number of en=0 cycles.
- Restart and zero load:
  - Stimulus: load 4'b1101 mid-count; later, load 4'b1000 on the expiry edge; finally, load 4'b0000.
  - Required:
    - 4'b1101 mid-count: q=13 next cycle, no tc.
    - 4'b1000 on the expiry edge: q=8 and no tc.
    - 4'b0000: q=0, state IDLE, no tc, done=0.
- Reload of one:
  - Stimulus: load 4'b0001, reload_mode=1, en=1 for 5 cycles.
  - Required: q=1 constant and tc=1 on every cycle after the first enabled edge.
